// File: rtl/alu_sequencer_if.sv
// Request/result handshake bundle for alu_sequencer.
// slave = sequencer side, master = requester/consumer side.
interface alu_sequencer_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   opcode;
    logic [W-1:0] operand1;
    logic [W-1:0] operand2;
    logic [5:0]   status_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result_hi;
    logic [W-1:0] result_lo;
    logic [5:0]   status_out;

    modport slave (
        input  in_valid, opcode, operand1, operand2, status_in, out_ready,
        output in_ready, out_valid, result_hi, result_lo, status_out
    );

    modport master (
        output in_valid, opcode, operand1, operand2, status_in, out_ready,
        input  in_ready, out_valid, result_hi, result_lo, status_out
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: 1-cycle ADD/SUB/SHR/SHL, shift-add MUL, restoring DIV on one shared adder.
// Optional macro ALU_SEQ_EARLY_TERM_EN: MUL stops once the remaining multiplier bits are zero.
module alu_sequencer #(
    parameter int W  = 16,
    parameter int CW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SHR = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_DIV = 3'b101;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_op;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_lo;
    logic [5:0]    r_st;

    logic [W:0]    w_add_a;
    logic [W:0]    w_add_b;
    logic          w_cin;
    logic [W+1:0]  w_sum;
    logic          w_v;
    logic [W:0]    w_shr;
    logic [W:0]    w_shl;
    logic [2*W-1:0] w_mul_nx;
    logic [2*W-1:0] w_mul_fin;
    logic          w_ge;
    logic [W-1:0]  w_rem_nx;
    logic [W-1:0]  w_q_nx;
    logic          w_exit;
    logic          w_unused;

    assign w_unused = ^{bus.status_in[5:2], bus.status_in[0]};

    // One adder serves ADD/SUB in IDLE and the MUL accumulate / DIV trial subtract in ITER.
    always_comb begin
        w_add_a = {1'b0, bus.operand1};
        w_add_b = {1'b0, bus.operand2};
        w_cin   = bus.status_in[1];
        if (r_state == S_ITER) begin
            if (r_op == OP_DIV) begin
                w_add_a = {r_hi, r_lo[W-1]};
                w_add_b = ~{1'b0, r_a};
                w_cin   = 1'b1;
            end else begin
                w_add_a = {1'b0, r_hi};
                w_add_b = {1'b0, r_a};
                w_cin   = 1'b0;
            end
        end else if (bus.opcode == OP_SUB) begin
            w_add_b = {1'b0, ~bus.operand2};
            w_cin   = 1'b1;
        end
    end

    assign w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{(W+1){1'b0}}, w_cin};
    assign w_v   = (w_add_a[W-1] == w_add_b[W-1]) && (w_sum[W-1] != w_add_a[W-1]);

    // Extra bit on the shifted-out side captures the last bit lost (C).
    assign w_shr = {bus.operand1, 1'b0} >> bus.operand2[3:0];
    assign w_shl = {1'b0, bus.operand1} << bus.operand2[3:0];

    assign w_mul_nx = r_lo[0] ? {w_sum[W:0], r_lo[W-1:1]} : {1'b0, r_hi, r_lo[W-1:1]};

    // Carry out of shifted - divisor means no borrow: quotient bit is 1.
    assign w_ge     = w_sum[W+1];
    assign w_rem_nx = w_ge ? w_sum[W-1:0] : {r_hi[W-2:0], r_lo[W-1]};
    assign w_q_nx   = {r_lo[W-2:0], w_ge};

`ifdef ALU_SEQ_EARLY_TERM_EN
    logic [W-1:0]  r_b;
    logic [CW-1:0] w_cnt_nx;
    logic [CW-1:0] w_align;

    assign w_cnt_nx  = r_cnt + 1'b1;
    // Product sits W-(cnt+1) bits too high when leaving early; shift it into place.
    assign w_align   = CW'(W-1) - r_cnt;
    assign w_mul_fin = w_mul_nx >> w_align;
    assign w_exit    = (r_cnt == CW'(W-1)) ||
                       ((r_op == OP_MUL) && ((r_b >> w_cnt_nx) == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_b <= '0;
        else if (r_state == S_IDLE && bus.in_valid)
            r_b <= bus.operand2;
    end
`else
    assign w_mul_fin = w_mul_nx;
    assign w_exit    = (r_cnt == CW'(W-1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_st    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_op  <= bus.opcode;
                    r_cnt <= '0;
                    case (bus.opcode)
                        OP_ADD, OP_SUB: begin
                            r_hi    <= '0;
                            r_lo    <= w_sum[W-1:0];
                            r_st    <= {2'b00, w_sum[W-1], w_v, w_sum[W], w_sum[W-1:0] == '0};
                            r_state <= S_DONE;
                        end
                        OP_SHR: begin
                            r_hi    <= '0;
                            r_lo    <= w_shr[W:1];
                            r_st    <= {2'b00, w_shr[W], 1'b0, w_shr[0], w_shr[W:1] == '0};
                            r_state <= S_DONE;
                        end
                        OP_SHL: begin
                            r_hi    <= '0;
                            r_lo    <= w_shl[W-1:0];
                            r_st    <= {2'b00, w_shl[W-1], 1'b0, w_shl[W], w_shl[W-1:0] == '0};
                            r_state <= S_DONE;
                        end
                        OP_MUL: begin
                            r_a     <= bus.operand1;
                            r_hi    <= '0;
                            r_lo    <= bus.operand2;
                            r_st    <= '0;
                            r_state <= S_ITER;
                        end
                        OP_DIV: begin
                            if (bus.operand2 == '0) begin
                                r_hi    <= bus.operand1;
                                r_lo    <= '1;
                                r_st    <= 6'b011000;
                                r_state <= S_DONE;
                            end else begin
                                r_a     <= bus.operand2;
                                r_hi    <= '0;
                                r_lo    <= bus.operand1;
                                r_st    <= '0;
                                r_state <= S_ITER;
                            end
                        end
                        default: begin
                            r_hi    <= '0;
                            r_lo    <= '0;
                            r_st    <= 6'b100000;
                            r_state <= S_DONE;
                        end
                    endcase
                end
                S_ITER: begin
                    if (r_op == OP_DIV) begin
                        r_hi <= w_rem_nx;
                        r_lo <= w_q_nx;
                    end else if (w_exit) begin
                        r_hi <= w_mul_fin[2*W-1:W];
                        r_lo <= w_mul_fin[W-1:0];
                    end else begin
                        r_hi <= w_mul_nx[2*W-1:W];
                        r_lo <= w_mul_nx[W-1:0];
                    end
                    if (w_exit) begin
                        r_state <= S_DONE;
                        if (r_op == OP_DIV)
                            r_st <= {2'b00, w_q_nx[W-1], 2'b00, w_q_nx == '0};
                        else
                            r_st <= {2'b00, w_mul_fin[2*W-1], 2'b00, w_mul_fin == '0};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: if (bus.out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.result_hi  = r_hi;
    assign bus.result_lo  = r_lo;
    assign bus.status_out = r_st;
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle sequencer for the 16-bit ALU datapath. It accepts one operation at a time over a valid/ready handshake and performs the operation:
- ADD/SUB/SHR/SHL in one cycle, using the ripple adder and barrel shifter.
- MUL as 16-iteration shift-add, DIV as 16-iteration restoring divide, both reusing one 16-bit adder.
It holds the result and status flags until the consumer accepts them. It fills the ALU top-level state-machine slot, between the register file/decoder and writeback.

Parameters:
- W, 16, operand width; iteration count equals W
- CW, 5, iteration counter width (ceil(log2(W))+1)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  sequencer can accept a request
- opcode  in  3  000 ADD, 001 SUB, 010 SHR, 011 SHL, 100 MUL, 101 DIV, 110/111 illegal
- operand1  in  W  A / multiplicand / dividend / shift source
- operand2  in  W  B / multiplier / divisor / shift amount (bits [3:0] only)
- status_in  in  6  incoming flags; only bit 1 (C) is used, as ADD carry-in
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result_hi  out  W  MUL upper product / DIV remainder / 0 otherwise
- result_lo  out  W  ADD/SUB/shift result / MUL lower product / DIV quotient
- status_out  out  6  {ILL, DZ, N, V, C, Z}

Behaviour:
- Reset (asynchronous, any state, including mid-iteration):
  - State goes to IDLE; counter=0.
  - in_ready=1, out_valid=0, result_hi=result_lo=0, status_out=0.
  - Any in-flight operation is discarded.
- States: IDLE, ITER, DONE.
  - IDLE: in_ready=1. When in_valid&&in_ready, operands and opcode are latched at that edge (E0).
  - Single-cycle ops, illegal opcodes and DIV with operand2==0: go to DONE at E0. out_valid=1 after E0, i.e. 1-cycle latency.
  - MUL/DIV otherwise: go to ITER at E0 with counter=0.
  - ITER: one iteration per cycle. counter increments each edge. After the edge where counter reaches W-1 (edge E16 for W=16), go to DONE. out_valid=1 after E16.
  - DONE: out_valid=1; result_hi, result_lo and status_out are held stable. On out_valid&&out_ready go to IDLE.
- in_ready=1 only in IDLE. There is no accept in the same cycle as a result handoff; the next request is accepted at the earliest one cycle after handoff.
- in_valid during ITER/DONE is ignored. The requester holds the request until in_ready.
- ADD: {C, result_lo} = A + B + status_in[1].
- SUB: result_lo = A - B; C = 1 if A >= B unsigned (no borrow).
- V (ADD/SUB only): two's-complement signed overflow. V=0 for all other ops.
- SHR/SHL: logical shift by operand2[3:0], zero fill. C = last bit shifted out; C=0 when the shift amount is 0.
- MUL: unsigned 16x16 -> 32 bits, {result_hi, result_lo}. C=0.
- DIV: unsigned. result_lo = quotient, result_hi = remainder.
  - Divide by zero: DZ=1, quotient=16'hFFFF, remainder=dividend, 1-cycle latency.
- Z: 1 when every W-bit result word is zero (for MUL the full 32 bits; for DIV the quotient only).
- N: MSB of result_lo; for MUL, MSB of result_hi.
- ILL: 1 for opcode 110/111; results=0 and all other flags 0.
- Flags other than C/V/N/Z/DZ/ILL are cleared; status_in is never passed through.

Optional Feature:
- ALU_SEQ_EARLY_TERM_EN defined:
  - MUL leaves ITER at the first edge where the remaining unshifted multiplier bits are all zero. The accumulator is aligned so the result is identical to the full run.
  - MUL latency becomes 1 + (index of the highest set multiplier bit), minimum 1. Multiplier 0 -> result at E0+1.
- Not defined: MUL is always W iterations. DIV is unaffected in both cases.

Test Plan:
- ADD A=16'hFFFF, B=16'h0001, status_in[1]=0 -> after 1 cycle: result_lo=0, C=1, Z=1, V=0.
- SUB A=16'h8000, B=16'h0001 -> result_lo=16'h7FFF, V=1, C=1, N=0. Then SHR A=16'h0005, B=1 -> result_lo=16'h0002, C=1.
- MUL 16'hFFFF x 16'hFFFF -> out_valid exactly 16 cycles after accept; result_hi=16'hFFFE, result_lo=16'h0001, N=1. Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
- DIV 100/7 -> after 16 cycles: result_lo=16'h000E, result_hi=16'h0002. DIV 9/0 -> after 1 cycle: DZ=1, result_lo=16'hFFFF, result_hi=16'h0009.
- Opcode 3'b111 -> ILL=1, results 0. Deassert rst_n during MUL iteration 8 -> outputs immediately 0, in_ready=1. A new ADD after release completes normally.
- With ALU_SEQ_EARLY_TERM_EN: MUL 16'h1234 x 16'h0003 -> result_lo=16'h369C, result_hi=0, out_valid 2 cycles after accept.
